// File: rtl/hop_pkg.sv
// hop_pkg: shared types and default configuration for the hop start/echo sequencer.
package hop_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FIRE,
        ST_WAIT,
        ST_GAP,
        ST_DONE
    } hop_state_t;

    // Default configuration
    localparam int HOP_DEPTH_DEF = 4;   // expected start-to-echo latency (cycles)
    localparam int TIMEOUT_DEF   = 15;  // last WAIT cycle before a pulse is declared lost
    localparam int CNT_W_DEF     = 8;   // pass/error counter width

endpackage

// File: rtl/hop_sat_cnt.sv
// hop_sat_cnt: up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module hop_sat_cnt
    import hop_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock0,
    input  logic             rst1,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    // Clear has priority; increments stop once the counter is full
    always_ff @(posedge clock0 or posedge rst1) begin
        if (rst1)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc && (q != '1))
            q <= q + CNT_W'(1);
    end

endmodule

// File: rtl/hop_start_seq.sv
// hop_start_seq: fires a burst of single-cycle start pulses into a downstream flop chain,
// times each returning echo and keeps pass/error tallies.
// Build option: define HOP_LAT_CHECK_EN to require every echo to arrive exactly HOP_DEPTH
// cycles after its start (and to report the measured latency on lat); without it any echo
// before the timeout passes and lat stays 0.
module hop_start_seq
    import hop_pkg::*;
#(
    parameter int HOP_DEPTH = HOP_DEPTH_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             clock0,
    input  logic             rst1,
    input  logic             en,
    input  logic [3:0]       burst_len,
    input  logic             echo,
    output logic             start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [3:0]       lat
);

    hop_state_t state, state_nxt;

    logic [3:0] timer;      // cycles spent in WAIT for the current pulse
    logic [3:0] tcur;       // timer value belonging to the current WAIT cycle
    logic [3:0] remaining;  // pulses still to be fired, including the one in flight
    logic       cnt_clr, pass_inc, err_inc;
    logic       rem_ld, rem_dec, tmr_clr, tmr_inc;
    logic       echo_ok;

    // A depth outside 1..TIMEOUT-1 could never be met before the timeout fires
    if (HOP_DEPTH < 1 || HOP_DEPTH >= TIMEOUT) begin : g_bad_hop_depth
    end

`ifdef HOP_LAT_CHECK_EN
    assign echo_ok = (tcur == 4'(HOP_DEPTH));

    // Capture the measured latency on every echo seen while waiting
    always_ff @(posedge clock0 or posedge rst1) begin
        if (rst1)
            lat <= '0;
        else if ((state == ST_WAIT) && echo)
            lat <= tcur;
    end
`else
    assign echo_ok = 1'b1;
    assign lat     = '0;
`endif

    // State register
    always_ff @(posedge clock0 or posedge rst1) begin
        if (rst1)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next state and datapath strobes; any echo outside WAIT is stray
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        pass_inc  = 1'b0;
        err_inc   = 1'b0;
        rem_ld    = 1'b0;
        rem_dec   = 1'b0;
        tmr_clr   = 1'b0;
        tmr_inc   = 1'b0;
        tcur      = timer + 4'd1;
        case (state)
            ST_IDLE: begin
                err_inc = echo;
                if (en && (burst_len != 4'd0)) begin
                    cnt_clr   = 1'b1;
                    rem_ld    = 1'b1;
                    state_nxt = ST_FIRE;
                end
            end
            ST_FIRE: begin
                err_inc   = echo;
                tmr_clr   = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                tmr_inc = 1'b1;
                if (echo) begin
                    pass_inc  = echo_ok;
                    err_inc   = !echo_ok;
                    state_nxt = ST_GAP;
                end else if (tcur == 4'(TIMEOUT)) begin
                    err_inc   = 1'b1;
                    state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                err_inc   = echo;
                rem_dec   = 1'b1;
                state_nxt = (remaining == 4'd1) ? ST_DONE : ST_FIRE;
            end
            ST_DONE: begin
                err_inc   = echo;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs registered from the next state so each is a clean flop
    always_ff @(posedge clock0 or posedge rst1) begin
        if (rst1) begin
            start <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            start <= (state_nxt == ST_FIRE);
            busy  <= (state_nxt != ST_IDLE);
            done  <= (state_nxt == ST_DONE);
        end
    end

    // WAIT timer and remaining-pulse counter
    always_ff @(posedge clock0 or posedge rst1) begin
        if (rst1) begin
            timer     <= '0;
            remaining <= '0;
        end else begin
            if (tmr_clr)
                timer <= '0;
            else if (tmr_inc)
                timer <= tcur;
            if (rem_ld)
                remaining <= burst_len;
            else if (rem_dec)
                remaining <= remaining - 4'd1;
        end
    end

    hop_sat_cnt #(.CNT_W(CNT_W)) u_pass_cnt (
        .clock0 (clock0),
        .rst1   (rst1),
        .clr    (cnt_clr),
        .inc    (pass_inc),
        .q      (pass_cnt)
    );

    hop_sat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
        .clock0 (clock0),
        .rst1   (rst1),
        .clr    (cnt_clr),
        .inc    (err_inc),
        .q      (err_cnt)
    );

endmodule

// File: tb/tb_hop_start_seq.sv
// tb_hop_start_seq: directed bench for hop_start_seq with an echo responder that returns
// each start pulse a programmable number of cycles later.
module tb_hop_start_seq;

`ifdef HOP_LAT_CHECK_EN
    localparam bit LATCHK = 1'b1;
`else
    localparam bit LATCHK = 1'b0;
`endif

    logic       clock0 = 1'b0;
    logic       rst1;
    logic       en;
    logic [3:0] burst_len;
    logic       echo;
    logic       start, busy, done;
    logic [7:0] pass_cnt, err_cnt;
    logic [3:0] lat;

    logic        echo_force;
    logic        resp_en;
    logic [3:0]  dly;
    logic [15:0] hist;

    int cyc = 0;
    int start_cnt = 0;
    int done_cnt = 0;
    int last_start = 0;
    int gap_last = 0;
    int gap_prev = 0;
    int done_cyc = 0;
    bit busy_seen = 1'b0;

    int n_cmp = 0;
    int n_mis = 0;

    hop_start_seq dut (
        .clock0    (clock0),
        .rst1      (rst1),
        .en        (en),
        .burst_len (burst_len),
        .echo      (echo),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .pass_cnt  (pass_cnt),
        .err_cnt   (err_cnt),
        .lat       (lat)
    );

    always #5 clock0 = ~clock0;

    always @(posedge clock0) cyc <= cyc + 1;

    // Responder: hist[d-1] holds the start value from d cycles ago
    always @(posedge clock0 or posedge rst1) begin
        if (rst1)
            hist <= '0;
        else
            hist <= {hist[14:0], start};
    end

    assign echo = echo_force | (resp_en & hist[dly - 4'd1]);

    // Monitor on the falling edge
    always @(negedge clock0) begin
        if (start) begin
            if (start_cnt > 0) begin
                gap_prev = gap_last;
                gap_last = cyc - last_start;
            end
            last_start = cyc;
            start_cnt++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy)
            busy_seen = 1'b1;
    end

    task automatic check_eq(input string tag, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic launch(input logic [3:0] n);
        @(negedge clock0);
        en = 1'b1;
        burst_len = n;
        @(negedge clock0);
        en = 1'b0;
        burst_len = 4'hF;  // changes while busy must be ignored
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int k;
        d0 = done_cnt;
        k = 0;
        while (done_cnt == d0 && k < budget) begin
            @(negedge clock0);
            k++;
        end
        check_eq("done_within_budget", int'(done_cnt != d0), 1);
        repeat (2) @(negedge clock0);
    endtask

    task automatic wait_starts(input int target, input int budget);
        int k;
        k = 0;
        while (start_cnt < target && k < budget) begin
            @(negedge clock0);
            k++;
        end
        check_eq("start_within_budget", int'(start_cnt >= target), 1);
    endtask

    initial begin
        int s0;
        int d0;
        rst1 = 1'b1;
        en = 1'b0;
        burst_len = 4'd0;
        echo_force = 1'b0;
        resp_en = 1'b0;
        dly = 4'd4;

        // Reset state
        repeat (3) @(negedge clock0);
        check_eq("rst_start", start, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_pass", pass_cnt, 0);
        check_eq("rst_err", err_cnt, 0);
        check_eq("rst_lat", lat, 0);
        rst1 = 1'b0;

        // Zero-length burst request does nothing
        s0 = start_cnt;
        en = 1'b1;
        burst_len = 4'd0;
        repeat (10) @(negedge clock0);
        en = 1'b0;
        check_eq("len0_busy_seen", busy_seen, 0);
        check_eq("len0_starts", start_cnt - s0, 0);
        check_eq("len0_dones", done_cnt, 0);

        // Three pulses echoed after 4 cycles
        resp_en = 1'b1;
        dly = 4'd4;
        s0 = start_cnt;
        d0 = done_cnt;
        launch(4'd3);
        wait_done(60);
        check_eq("b3_starts", start_cnt - s0, 3);
        check_eq("b3_gap1", gap_prev, 6);
        check_eq("b3_gap2", gap_last, 6);
        check_eq("b3_pass", pass_cnt, 3);
        check_eq("b3_err", err_cnt, 0);
        check_eq("b3_lat", lat, LATCHK ? 4 : 0);
        check_eq("b3_dones", done_cnt - d0, 1);
        check_eq("b3_busy_after", busy, 0);

        // Lost pulse: full timeout, then GAP and DONE
        resp_en = 1'b0;
        launch(4'd1);
        wait_done(60);
        check_eq("lost_start_to_done", done_cyc - last_start, 17);
        check_eq("lost_err", err_cnt, 1);
        check_eq("lost_pass", pass_cnt, 0);

        // Echo one cycle late relative to HOP_DEPTH
        resp_en = 1'b1;
        dly = 4'd5;
        launch(4'd1);
        wait_done(60);
        check_eq("late_pass", pass_cnt, LATCHK ? 0 : 1);
        check_eq("late_err", err_cnt, LATCHK ? 1 : 0);
        check_eq("late_lat", lat, LATCHK ? 5 : 0);

        // Asynchronous reset during WAIT of the second pulse of a five-pulse burst
        dly = 4'd4;
        s0 = start_cnt;
        launch(4'd5);
        wait_starts(s0 + 2, 100);
        repeat (2) @(negedge clock0);
        check_eq("abort_pass_before", pass_cnt, 1);
        check_eq("abort_busy_before", busy, 1);
        #2 rst1 = 1'b1;
        #1;
        check_eq("abort_start", start, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done, 0);
        check_eq("abort_pass", pass_cnt, 0);
        check_eq("abort_err", err_cnt, 0);
        check_eq("abort_lat", lat, 0);
        d0 = done_cnt;
        en = 1'b1;
        burst_len = 4'd2;
        repeat (3) @(negedge clock0);
        check_eq("abort_no_done", done_cnt - d0, 0);
        check_eq("abort_busy_in_rst", busy, 0);
        rst1 = 1'b0;
        #1;
        check_eq("restart_not_early", busy, 0);
        @(negedge clock0);
        en = 1'b0;
        check_eq("restart_busy", busy, 1);
        wait_done(60);
        check_eq("restart_pass", pass_cnt, 2);
        check_eq("restart_err", err_cnt, 0);

        // Stray echo held in IDLE saturates the error counter
        resp_en = 1'b0;
        s0 = start_cnt;
        echo_force = 1'b1;
        repeat (300) @(negedge clock0);
        echo_force = 1'b0;
        @(negedge clock0);
        check_eq("sat_err", err_cnt, 255);
        check_eq("sat_busy", busy, 0);
        check_eq("sat_starts", start_cnt - s0, 0);
        check_eq("sat_pass_hold", pass_cnt, 2);

        // Next burst clears both counters
        resp_en = 1'b1;
        dly = 4'd4;
        launch(4'd1);
        wait_done(60);
        check_eq("clr_err", err_cnt, 0);
        check_eq("clr_pass", pass_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got %0d cycles, expected completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hop_start_seq.md
HOP_START_SEQ -- requirements
Module: hop_start_seq

Interface
REQ-001 SHALL have parameter HOP_DEPTH, default 4, expected start-to-echo latency in clock0 cycles (range 1..14).
REQ-002 SHALL have parameter TIMEOUT, default 15, maximum WAIT cycles before a pulse is declared lost (range HOP_DEPTH+1..15).
REQ-003 SHALL have parameter CNT_W, default 8, width of the pass and error counters.
REQ-004 SHALL have port clock0  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst1  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port en  input  1  burst request; sampled only in IDLE.
REQ-007 SHALL have port burst_len  input  4  number of pulses per burst; sampled only in IDLE.
REQ-008 SHALL have port echo  input  1  returned pulse from the downstream flop chain.
REQ-009 SHALL have port start  output  1  registered single-cycle pulse that feeds the downstream chain.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port done  output  1  single-cycle burst-complete pulse.
REQ-012 SHALL have port pass_cnt  output  CNT_W  pulses echoed correctly in the current or last burst.
REQ-013 SHALL have port err_cnt  output  CNT_W  lost, mistimed or stray pulses.
REQ-014 SHALL have port lat  output  4  latency of the most recent echo.

Function
REQ-015 SHALL implement FSM states IDLE, FIRE, WAIT, GAP and DONE, all registered.
REQ-016 IDLE: when en=1 and burst_len!=0, SHALL load remaining=burst_len, clear pass_cnt and err_cnt, and go to FIRE; when burst_len=0, SHALL stay in IDLE with no done pulse.
REQ-017 FIRE: start=1 for exactly this one cycle, timer cleared to 0, then go to WAIT; start SHALL be 0 in all other states.
REQ-018 WAIT: timer SHALL increment each cycle, so the first WAIT cycle has timer=1; echo is then judged against timer (a pulse with start high in cycle N and echo high in cycle N+4 gives timer=4).
REQ-019 WAIT with echo=1: lat<=timer, pass or err is updated per REQ-029/030, and the FSM goes to GAP.
REQ-020 WAIT with echo=0 and timer=TIMEOUT: err_cnt SHALL increment and the FSM goes to GAP; if echo=1 on the same cycle, the echo rule (REQ-019) wins.
REQ-021 GAP: one drain cycle in which remaining decrements; go to DONE when the new remaining is 0, otherwise to FIRE.
REQ-022 DONE: done=1 for one cycle, then go to IDLE; counters hold their values until the next burst starts.
REQ-023 echo=1 in IDLE, FIRE, GAP or DONE SHALL be a stray pulse and increment err_cnt; the state SHALL be unaffected.
REQ-024 pass_cnt and err_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-025 en and burst_len changes while busy=1 SHALL be ignored; a burst always completes.

Reset
REQ-026 While rst1=1: state=IDLE; start, busy and done=0; pass_cnt, err_cnt, lat, timer and remaining=0.
REQ-027 rst1 asserted mid-burst SHALL abort the burst immediately, with no done pulse.
REQ-028 After rst1 deasserts, the FSM SHALL first leave IDLE no earlier than the first clock0 edge after deassertion.

Configuration
REQ-029 With HOP_LAT_CHECK_EN defined, an echo passes only when timer==HOP_DEPTH; any other timer value increments err_cnt, and lat updates on every echo.
REQ-030 Without HOP_LAT_CHECK_EN, any echo in WAIT before timeout passes, lat SHALL remain 0, and the comparator logic SHALL be absent.

Structure
REQ-031 Package hop_pkg SHALL hold the state enum and the default HOP_DEPTH, TIMEOUT and CNT_W constants.
REQ-032 A sub-module hop_sat_cnt (saturating counter with clear and increment) SHALL be instantiated twice, once for pass_cnt and once for err_cnt.

Verification
REQ-033 burst_len=3, echo returned 4 cycles after each start -> three start pulses 6 cycles apart, pass_cnt=3, err_cnt=0, lat=4, one done pulse.
REQ-034 burst_len=1, echo never returned -> WAIT holds 15 cycles, err_cnt=1, done pulse follows.
REQ-035 HOP_LAT_CHECK_EN defined, echo at timer=5 -> err_cnt=1, lat=5; macro undefined, same stimulus -> pass_cnt=1, lat=0.
REQ-036 rst1 pulsed during WAIT of a 5-pulse burst -> all outputs 0 asynchronously, no done pulse, a new burst restarts cleanly.
REQ-037 echo held high in IDLE for 300 cycles with CNT_W=8 -> err_cnt saturates at 255.
REQ-038 burst_len=0 with en=1 -> busy stays 0, start never asserts.
